ahb_sram_slave_ws: RTL

//  Parametrised AHB-Lite SRAM slave that replaces the fixed 8 KB zero-wait SRAM slave.

---
 rtl/ahb_sram_slave_ws.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ahb_sram_slave_ws.sv
// AHB-Lite SRAM slave: parametrised width/depth/base, programmable wait states,
// write-to-read forwarding and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave_ws #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           MEM_BYTES   = 8192,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP
);

  localparam int unsigned NB     = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = $clog2(NB);
  localparam int unsigned WORDS  = MEM_BYTES / NB;
  localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [2:0]            MAX_SIZE = 3'(LANE_W);
  localparam logic [ADDR_WIDTH-1:0] MEM_SPAN = ADDR_WIDTH'(MEM_BYTES);
  localparam logic [2:0]            CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       hreadyout_nxt;
  logic [1:0] hresp_nxt;

  logic             pend_valid;
  logic             pend_write;
  logic [IDX_W-1:0] pend_idx;
  logic [NB-1:0]    pend_mask;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic [ADDR_WIDTH-1:0] offset_c;
  logic [7:0]            size_bytes_c;
  logic [NB-1:0]         mask_c;
  logic [IDX_W-1:0]      idx_c;
  logic                  err_c;
  logic                  sample_c;
  logic                  ok_sample_c;
  logic                  commit_c;
  logic [DATA_WIDTH-1:0] rd_word_c;
  logic                  unused_c;

  // HTRANS[0] only separates NONSEQ from SEQ, which this slave treats alike
  assign unused_c = HTRANS[0];

  // Address-phase decode: word index, byte lanes and legality
  always_comb begin
    offset_c     = HADDR - BASE_ADDR;
    size_bytes_c = 8'd1 << HSIZE;
    mask_c       = ((NB'(1) << size_bytes_c) - NB'(1)) << HADDR[LANE_W-1:0];
    idx_c        = offset_c[LANE_W +: IDX_W];
    err_c        = (HSIZE > MAX_SIZE)
                || ((HADDR[7:0] & (size_bytes_c - 8'd1)) != 8'd0)
                || (HADDR < BASE_ADDR)
                || (offset_c >= MEM_SPAN);
    sample_c     = (state == ST_IDLE) && HSEL && HREADY && HTRANS[1];
    ok_sample_c  = sample_c && !err_c;
    commit_c     = (state == ST_IDLE) && pend_valid && pend_write && !HRESET;
  end

  // Read word with the committing write's lanes merged in for W->R coherence
  always_comb begin
    rd_word_c = mem[idx_c];
    if (commit_c && (pend_idx == idx_c)) begin
      for (int b = 0; b < NB; b++) begin
        if (pend_mask[b]) rd_word_c[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  // Next state, wait counter and registered response outputs
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hreadyout_nxt = 1'b1;
    hresp_nxt     = 2'b00;
    unique case (state)
      ST_IDLE: begin
        if (sample_c) begin
          if (err_c) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 3'd0) state_nxt = ST_IDLE;
        else             cnt_nxt   = cnt - 3'd1;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    hreadyout_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_ERR2);
    hresp_nxt     = ((state_nxt == ST_ERR1) || (state_nxt == ST_ERR2)) ? 2'b01 : 2'b00;
  end

  // FSM state, counter and response registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      HREADYOUT <= 1'b1;
      HRESP     <= 2'b00;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      HREADYOUT <= hreadyout_nxt;
      HRESP     <= hresp_nxt;
    end
  end

  // Pending transfer: captured on a legal sample, retired when the data phase ends
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_valid <= 1'b0;
      pend_write <= 1'b0;
      pend_idx   <= '0;
      pend_mask  <= '0;
    end else if (ok_sample_c) begin
      pend_valid <= 1'b1;
      pend_write <= HWRITE;
      pend_idx   <= idx_c;
      pend_mask  <= mask_c;
    end else if (state == ST_IDLE) begin
      pend_valid <= 1'b0;
    end
  end

  // Read data captured at the sample edge and held until the next legal read
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HRDATA <= '0;
    end else if (ok_sample_c && !HWRITE) begin
      HRDATA <= rd_word_c;
    end
  end

  // Byte-lane write into the array (contents survive reset)
  always_ff @(posedge HCLK) begin
    if (commit_c) begin
      for (int b = 0; b < NB; b++) begin
        if (pend_mask[b]) mem[pend_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule
